// File: rtl/tftp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : tftp_rx_parser
// Purpose  : Receive-side TFTP packet parser. Skips the Ethernet/IP/UDP
//            header, decodes the TFTP opcode (RRQ, WRQ, DATA, ACK, ERROR),
//            captures opcode and block number / error code, streams string
//            and DATA payload bytes in the same cycle they arrive, and flags
//            malformed packets.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   HDR_OFFSET  : byte index of the TFTP opcode MSB within the frame
//   MAX_STR_LEN : max filename / mode / error-message bytes, NUL included
//   MAX_DATA    : max DATA payload bytes
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   rx_valid_i    : rx_data_i holds a byte this cycle
//   rx_data_i     : frame byte, network order
//   rx_sof_i      : byte is frame index 0
//   rx_eof_i      : byte is the last TFTP byte
//   opcode_o      : captured opcode (registered)
//   block_no_o    : captured block number / error code (registered)
//   str_valid_o   : rx_data_i is a string byte (combinational)
//   str_sel_o     : 0 filename, 1 mode, 2 error message
//   data_valid_o  : rx_data_i is a DATA payload byte (combinational)
//   data_len_o    : payload byte count, valid with pkt_done_o
//   last_block_o  : data_len_o < MAX_DATA, valid with pkt_done_o on DATA
//   pkt_done_o    : one-cycle pulse, well-formed packet completed
//   pkt_err_o     : one-cycle pulse, packet rejected
//   err_cause_o   : 1 bad opcode, 2 truncated, 3 string overflow,
//                   4 payload too long; valid with pkt_err_o
// ============================================================================
module tftp_rx_parser #(
  parameter int HDR_OFFSET  = 42,
  parameter int MAX_STR_LEN = 64,
  parameter int MAX_DATA    = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_sof_i,
  input  logic        rx_eof_i,
  output logic [15:0] opcode_o,
  output logic [15:0] block_no_o,
  output logic        str_valid_o,
  output logic [1:0]  str_sel_o,
  output logic        data_valid_o,
  output logic [9:0]  data_len_o,
  output logic        last_block_o,
  output logic        pkt_done_o,
  output logic        pkt_err_o,
  output logic [2:0]  err_cause_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HDR      = 4'd1,
    S_OPC_HI   = 4'd2,
    S_OPC_LO   = 4'd3,
    S_BLK_HI   = 4'd4,
    S_BLK_LO   = 4'd5,
    S_FNAME    = 4'd6,
    S_MODE     = 4'd7,
    S_ERRMSG   = 4'd8,
    S_PAYLOAD  = 4'd9,
    S_WAIT_EOF = 4'd10,
    S_DROP     = 4'd11
  } state_t;

  localparam logic [15:0] HDR_LAST     = 16'(HDR_OFFSET - 1);
  localparam logic [15:0] STR_LAST     = 16'(MAX_STR_LEN - 1);
  localparam logic [15:0] DATA_MAX     = 16'(MAX_DATA);
  localparam logic [2:0]  CAUSE_BADOP  = 3'd1;
  localparam logic [2:0]  CAUSE_TRUNC  = 3'd2;
  localparam logic [2:0]  CAUSE_STROVF = 3'd3;
  localparam logic [2:0]  CAUSE_DATOVF = 3'd4;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;          // index of the next byte to arrive
  logic [7:0]  opc_hi_q, opc_hi_d;
  logic [15:0] opcode_q, opcode_d;
  logic [7:0]  blk_hi_q, blk_hi_d;
  logic [15:0] block_no_q, block_no_d;
  logic [15:0] str_cnt_q, str_cnt_d;  // bytes streamed in the current string
  logic [15:0] pay_cnt_q, pay_cnt_d;  // payload bytes streamed
  logic [2:0]  cause_q, cause_d;      // reason recorded on entering DROP
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  err_cause_q, err_cause_d;
  logic [9:0]  data_len_q, data_len_d;
  logic        last_block_q, last_block_d;
  logic        eof_ok;                // field set complete once this byte lands

  logic in_str;
  logic str_room;
  logic pay_room;

  assign in_str   = (state_q == S_FNAME) || (state_q == S_MODE) || (state_q == S_ERRMSG);
  // The byte that would fill the last slot without being a NUL is withheld.
  assign str_room = (str_cnt_q < STR_LAST) || (rx_data_i == 8'h00);
  assign pay_room = (pay_cnt_q < DATA_MAX);

  // An sof byte always belongs to a new frame's header, never to a stream.
  assign str_valid_o  = rx_valid_i && !rx_sof_i && in_str && str_room;
  assign data_valid_o = rx_valid_i && !rx_sof_i && (state_q == S_PAYLOAD) && pay_room;

  always_comb begin
    str_sel_o = 2'd0;
    case (state_q)
      S_MODE:   str_sel_o = 2'd1;
      S_ERRMSG: str_sel_o = 2'd2;
      default:  str_sel_o = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    opc_hi_d     = opc_hi_q;
    opcode_d     = opcode_q;
    blk_hi_d     = blk_hi_q;
    block_no_d   = block_no_q;
    str_cnt_d    = str_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    cause_d      = cause_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_cause_d  = err_cause_q;
    data_len_d   = data_len_q;
    last_block_d = last_block_q;
    eof_ok       = 1'b0;

    if (rx_valid_i) begin
      if (rx_sof_i) begin
        // A frame still in flight is abandoned as truncated.
        if (state_q != S_IDLE) begin
          err_d       = 1'b1;
          err_cause_d = CAUSE_TRUNC;
        end
        idx_d     = 16'd1;
        str_cnt_d = 16'd0;
        pay_cnt_d = 16'd0;
        cause_d   = 3'd0;
        if (HDR_OFFSET == 0) begin
          opc_hi_d = rx_data_i;
          state_d  = S_OPC_LO;
        end else if (HDR_OFFSET == 1) begin
          state_d = S_OPC_HI;
        end else begin
          state_d = S_HDR;
        end
        // A single-byte frame can never carry a complete TFTP header.
        if (rx_eof_i) begin
          err_d       = 1'b1;
          err_cause_d = CAUSE_TRUNC;
          state_d     = S_IDLE;
        end
      end else if (state_q != S_IDLE) begin
        idx_d = idx_q + 16'd1;
        case (state_q)
          S_HDR: begin
            if (idx_q == HDR_LAST) state_d = S_OPC_HI;
          end
          S_OPC_HI: begin
            opc_hi_d = rx_data_i;
            state_d  = S_OPC_LO;
          end
          S_OPC_LO: begin
            opcode_d = {opc_hi_q, rx_data_i};
            case ({opc_hi_q, rx_data_i})
              16'd1, 16'd2:         state_d = S_FNAME;
              16'd3, 16'd4, 16'd5:  state_d = S_BLK_HI;
              default: begin
                state_d = S_DROP;
                cause_d = CAUSE_BADOP;
              end
            endcase
          end
          S_BLK_HI: begin
            blk_hi_d = rx_data_i;
            state_d  = S_BLK_LO;
          end
          S_BLK_LO: begin
            block_no_d = {blk_hi_q, rx_data_i};
            case (opcode_q)
              16'd3:   state_d = S_PAYLOAD;
              16'd4:   state_d = S_WAIT_EOF;
              default: state_d = S_ERRMSG;
            endcase
            eof_ok = (opcode_q == 16'd3) || (opcode_q == 16'd4);
          end
          S_FNAME, S_MODE, S_ERRMSG: begin
            if (rx_data_i == 8'h00) begin
              str_cnt_d = 16'd0;
              state_d   = (state_q == S_FNAME) ? S_MODE : S_WAIT_EOF;
              eof_ok    = (state_q != S_FNAME);
            end else if (!str_room) begin
              state_d = S_DROP;
              cause_d = CAUSE_STROVF;
            end else begin
              str_cnt_d = str_cnt_q + 16'd1;
            end
          end
          S_PAYLOAD: begin
            if (pay_room) begin
              pay_cnt_d = pay_cnt_q + 16'd1;
              eof_ok    = 1'b1;
            end else begin
              state_d = S_DROP;
              cause_d = CAUSE_DATOVF;
            end
          end
          S_WAIT_EOF: eof_ok = 1'b1;
          S_DROP:     eof_ok = 1'b0;
          default:    state_d = S_IDLE;
        endcase

        if (rx_eof_i) begin
          if (eof_ok) begin
            done_d       = 1'b1;
            data_len_d   = pay_cnt_d[9:0];
            last_block_d = (opcode_q == 16'd3) && (pay_cnt_d < DATA_MAX);
          end else begin
            err_d       = 1'b1;
            // A fault detected earlier (or on this byte) outranks truncation.
            err_cause_d = (state_d == S_DROP) ? cause_d : CAUSE_TRUNC;
          end
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 16'd0;
      opc_hi_q     <= 8'd0;
      opcode_q     <= 16'd0;
      blk_hi_q     <= 8'd0;
      block_no_q   <= 16'd0;
      str_cnt_q    <= 16'd0;
      pay_cnt_q    <= 16'd0;
      cause_q      <= 3'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_cause_q  <= 3'd0;
      data_len_q   <= 10'd0;
      last_block_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      opc_hi_q     <= opc_hi_d;
      opcode_q     <= opcode_d;
      blk_hi_q     <= blk_hi_d;
      block_no_q   <= block_no_d;
      str_cnt_q    <= str_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      cause_q      <= cause_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_cause_q  <= err_cause_d;
      data_len_q   <= data_len_d;
      last_block_q <= last_block_d;
    end
  end

  assign opcode_o     = opcode_q;
  assign block_no_o   = block_no_q;
  assign data_len_o   = data_len_q;
  assign last_block_o = last_block_q;
  assign pkt_done_o   = done_q;
  assign pkt_err_o    = err_q;
  assign err_cause_o  = err_cause_q;

endmodule
`default_nettype wire

// File: tb/tb_tftp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_tftp_rx_parser
// Purpose  : Scoreboard bench for tftp_rx_parser. Stimulus pushes the
//            expected packet outcome; a monitor pops and compares on every
//            pkt_done / pkt_err pulse, including stream byte counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tftp_rx_parser;

  localparam int HDR = 42;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic [15:0] opcode;
  logic [15:0] block_no;
  logic        str_valid;
  logic [1:0]  str_sel;
  logic        data_valid;
  logic [9:0]  data_len;
  logic        last_block;
  logic        pkt_done;
  logic        pkt_err;
  logic [2:0]  err_cause;

  tftp_rx_parser #(.HDR_OFFSET(HDR), .MAX_STR_LEN(64), .MAX_DATA(512)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .rx_sof_i     (rx_sof),
    .rx_eof_i     (rx_eof),
    .opcode_o     (opcode),
    .block_no_o   (block_no),
    .str_valid_o  (str_valid),
    .str_sel_o    (str_sel),
    .data_valid_o (data_valid),
    .data_len_o   (data_len),
    .last_block_o (last_block),
    .pkt_done_o   (pkt_done),
    .pkt_err_o    (pkt_err),
    .err_cause_o  (err_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [2:0]  cause;
    logic [15:0] opc;
    bit          chk_blk;
    logic [15:0] blk;
    bit          chk_len;
    logic [9:0]  len;
    bit          last;
    int          n_fn;   // -1 means do not check
    int          n_md;
    int          n_em;
    int          n_dat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  bit          pend_valid = 1'b0;
  logic [7:0]  fr[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          c_fn = 0, c_md = 0, c_em = 0, c_dat = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input bit is_err, input logic [2:0] cause, input logic [15:0] opc,
                              input bit chk_blk, input logic [15:0] blk,
                              input bit chk_len, input logic [9:0] len, input bit last,
                              input int n_fn, input int n_md, input int n_em, input int n_dat);
    exp_t e;
    e.is_err = is_err; e.cause = cause; e.opc = opc;
    e.chk_blk = chk_blk; e.blk = blk;
    e.chk_len = chk_len; e.len = len; e.last = last;
    e.n_fn = n_fn; e.n_md = n_md; e.n_em = n_em; e.n_dat = n_dat;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: compares on each pulse, then accumulates this cycle's stream
  // bytes (bytes streamed in a pulse cycle belong to the next packet).
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      c_fn = 0; c_md = 0; c_em = 0; c_dat = 0;
    end else begin
      if (pkt_done || pkt_err) begin
        chk("pulse_exclusive", 32'(pkt_done & pkt_err), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse (t=%0t)",
                   pkt_done, pkt_err, $time);
        end else begin
          me = sb.pop_front();
          chk("pkt_err_kind", 32'(pkt_err), 32'(me.is_err));
          chk("pulse_cycle", 32'(cyc), 32'(me.cyc));
          chk("opcode", 32'(opcode), 32'(me.opc));
          if (me.is_err) chk("err_cause", 32'(err_cause), 32'(me.cause));
          if (me.chk_blk) chk("block_no", 32'(block_no), 32'(me.blk));
          if (me.chk_len) begin
            chk("data_len", 32'(data_len), 32'(me.len));
            chk("last_block", 32'(last_block), 32'(me.last));
          end
          if (me.n_fn >= 0) chk("fname_bytes", 32'(c_fn), 32'(me.n_fn));
          if (me.n_md >= 0) chk("mode_bytes", 32'(c_md), 32'(me.n_md));
          if (me.n_em >= 0) chk("errmsg_bytes", 32'(c_em), 32'(me.n_em));
          if (me.n_dat >= 0) chk("data_bytes", 32'(c_dat), 32'(me.n_dat));
        end
        c_fn = 0; c_md = 0; c_em = 0; c_dat = 0;
      end
      if (str_valid) begin
        case (str_sel)
          2'd0:    c_fn++;
          2'd1:    c_md++;
          default: c_em++;
        endcase
      end
      if (data_valid) c_dat++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit sof, input bit eof);
    rx_valid = 1'b1; rx_data = b; rx_sof = sof; rx_eof = eof;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, input bit with_eof);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], i == 0, with_eof && (i == fr.size() - 1));
      if (i == 0 && pend_valid) begin
        pend.cyc = cyc;
        sb.push_back(pend);
        pend_valid = 1'b0;
      end
      if (gap_max > 0 && i != fr.size() - 1)
        repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic expect_now(input exp_t e);
    exp_t t;
    t = e;
    t.cyc = cyc;
    sb.push_back(t);
  endtask

  task automatic start_frame(input logic [7:0] op_hi, input logic [7:0] op_lo);
    fr.delete();
    for (int i = 0; i < HDR; i++) fr.push_back(8'(i) ^ 8'hA5);
    fr.push_back(op_hi);
    fr.push_back(op_lo);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) fr.push_back(s[i]);
    fr.push_back(8'h00);
  endtask

  task automatic add_bytes(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) fr.push_back(8'(i) + seed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0; rx_eof = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_block_no", 32'(block_no), 32'd0);
    chk("rst_data_len", 32'(data_len), 32'd0);
    chk("rst_err_cause", 32'(err_cause), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_err", 32'(pkt_err), 32'd0);
    chk("rst_last_block", 32'(last_block), 32'd0);

    // ACK block 0x0102, eof on block LSB
    start_frame(8'h00, 8'h04); fr.push_back(8'h01); fr.push_back(8'h02);
    send_frame(0, 1);
    expect_now(mk(0, 3'd0, 16'd4, 1, 16'h0102, 0, 10'd0, 0, 0, 0, 0, 0));

    // DATA block 7, full 512-byte payload
    start_frame(8'h00, 8'h03); fr.push_back(8'h00); fr.push_back(8'h07); add_bytes(512, 8'h11);
    send_frame(0, 1);
    expect_now(mk(0, 3'd0, 16'd3, 1, 16'h0007, 1, 10'd512, 0, 0, 0, 0, 512));

    // DATA block 8, 100 bytes -> last block
    start_frame(8'h00, 8'h03); fr.push_back(8'h00); fr.push_back(8'h08); add_bytes(100, 8'h40);
    send_frame(1, 1);
    expect_now(mk(0, 3'd0, 16'd3, 1, 16'h0008, 1, 10'd100, 1, 0, 0, 0, 100));

    // WRQ "a.bin\0octet\0" with rx_valid gaps
    start_frame(8'h00, 8'h02); add_str("a.bin"); add_str("octet");
    send_frame(2, 1);
    expect_now(mk(0, 3'd0, 16'd2, 0, 16'd0, 0, 10'd0, 0, 6, 6, 0, 0));

    // Unknown opcode 9
    start_frame(8'h00, 8'h09); fr.push_back(8'h7A); fr.push_back(8'h7A);
    send_frame(0, 1);
    expect_now(mk(1, 3'd1, 16'd9, 0, 16'd0, 0, 10'd0, 0, 0, 0, 0, 0));

    // RRQ filename of 64 non-NUL bytes -> string overflow
    start_frame(8'h00, 8'h01);
    for (int i = 0; i < 64; i++) fr.push_back(8'h78);
    add_str("octet");
    send_frame(0, 1);
    expect_now(mk(1, 3'd3, 16'd1, 0, 16'd0, 0, 10'd0, 0, -1, 0, 0, 0));

    // DATA with 513 payload bytes -> payload too long, 512 streamed
    start_frame(8'h00, 8'h03); fr.push_back(8'h00); fr.push_back(8'h09); add_bytes(513, 8'h03);
    send_frame(0, 1);
    expect_now(mk(1, 3'd4, 16'd3, 0, 16'd0, 0, 10'd0, 0, 0, 0, 0, 512));

    // eof on the opcode LSB -> truncated
    start_frame(8'h00, 8'h04);
    send_frame(0, 1);
    expect_now(mk(1, 3'd2, 16'd4, 0, 16'd0, 0, 10'd0, 0, 0, 0, 0, 0));

    // ERROR code 1, message "no\0"
    start_frame(8'h00, 8'h05); fr.push_back(8'h00); fr.push_back(8'h01); add_str("no");
    send_frame(1, 1);
    expect_now(mk(0, 3'd0, 16'd5, 1, 16'h0001, 0, 10'd0, 0, 0, 0, 3, 0));

    // RRQ aborted mid-filename by a new ACK frame
    start_frame(8'h00, 8'h01); fr.push_back(8'h61); fr.push_back(8'h62);
    send_frame(0, 0);
    pend = mk(1, 3'd2, 16'd1, 0, 16'd0, 0, 10'd0, 0, 2, 0, 0, 0);
    pend_valid = 1'b1;
    start_frame(8'h00, 8'h04); fr.push_back(8'h00); fr.push_back(8'h05);
    send_frame(0, 1);
    expect_now(mk(0, 3'd0, 16'd4, 1, 16'h0005, 0, 10'd0, 0, 0, 0, 0, 0));

    // Back-to-back zero-length DATA: legal, last block
    start_frame(8'h00, 8'h03); fr.push_back(8'h00); fr.push_back(8'h0A);
    send_frame(0, 1);
    expect_now(mk(0, 3'd0, 16'd3, 1, 16'h000A, 1, 10'd0, 1, 0, 0, 0, 0));

    // DATA interrupted by reset mid-payload: no pulse, outputs cleared
    start_frame(8'h00, 8'h03); fr.push_back(8'h0A); fr.push_back(8'h0B); add_bytes(10, 8'h20);
    send_frame(0, 0);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst2_opcode", 32'(opcode), 32'd0);
    chk("rst2_block_no", 32'(block_no), 32'd0);
    chk("rst2_err_cause", 32'(err_cause), 32'd0);
    chk("rst2_last_block", 32'(last_block), 32'd0);
    chk("rst2_data_len", 32'(data_len), 32'd0);

    // Parser recovers after reset
    start_frame(8'h00, 8'h04); fr.push_back(8'h0B); fr.push_back(8'hAD);
    send_frame(0, 1);
    expect_now(mk(0, 3'd0, 16'd4, 1, 16'h0BAD, 0, 10'd0, 0, 0, 0, 0, 0));

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
